// File: rtl/fifo_ctrl.sv
// Control half of an 8-entry FIFO: pointers, occupancy, status flags and the
// register-file handshake. Define FIFO_CTRL_ALMOST_EN to add almost_full/almost_empty.
module fifo_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] din,
   input  logic [DATA_W-1:0] rf_rData,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wAddr,
   output logic [DATA_W-1:0] rf_wData,
   output logic [ADDR_W-1:0] rf_rAddr,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              wr_ack,
   output logic              wr_err,
   output logic              rd_ack,
   output logic              rd_err,
`ifdef FIFO_CTRL_ALMOST_EN
   output logic              almost_full,
   output logic              almost_empty,
`endif
   output logic [ADDR_W:0]   data_count
);

   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   typedef enum logic [2:0] {
      IDLE, WRITE, READ, WR_RD, WR_ERR, RD_ERR, WR_ERR_RD, WR_RD_ERR
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] head, tail;
   logic              push_ok, pop_ok;

   assign full     = (data_count == FULL_CNT);
   assign empty    = (data_count == '0);
   assign push_ok  = wr_en & ~full;
   assign pop_ok   = rd_en & ~empty;

   assign rf_we    = push_ok & ~reset;
   assign rf_wAddr = tail;
   assign rf_wData = din;
   assign rf_rAddr = head;

`ifdef FIFO_CTRL_ALMOST_EN
   assign almost_full  = (data_count >= FULL_CNT - CNT_ONE);
   assign almost_empty = (data_count <= CNT_ONE);
`endif

   // Full and empty are never both true, so each request pair maps to exactly one state.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
      state_nxt = IDLE;
      case ({wr_en, rd_en})
         2'b10:   state_nxt = full  ? WR_ERR : WRITE;
         2'b01:   state_nxt = empty ? RD_ERR : READ;
         2'b11:   state_nxt = full  ? WR_ERR_RD : (empty ? WR_RD_ERR : WR_RD);
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: only control state is reset; the register file keeps its contents, which are
         // unreachable once head == tail and the count is zero.
         head       <= '0;
         tail       <= '0;
         data_count <= '0;
         dout       <= '0;
         state      <= IDLE;
      end else begin
         state <= state_nxt;
         if (push_ok) tail <= tail + PTR_ONE;
         if (pop_ok) begin
            head <= head + PTR_ONE;
            dout <= rf_rData;
         end
         case ({push_ok, pop_ok})
            2'b10:   data_count <= data_count + CNT_ONE;
            2'b01:   data_count <= data_count - CNT_ONE;
            default: data_count <= data_count;
         endcase
      end
   end

   assign wr_ack = (state == WRITE)  || (state == WR_RD)     || (state == WR_RD_ERR);
   assign wr_err = (state == WR_ERR) || (state == WR_ERR_RD);
   assign rd_ack = (state == READ)   || (state == WR_RD)     || (state == WR_ERR_RD);
   assign rd_err = (state == RD_ERR) || (state == WR_RD_ERR);

endmodule
